// File: rtl/dsi_ahb_pkg.sv
// dsi_ahb_pkg: bus encodings, register map and data-phase bundle
// shared by the DSI AHB slave front-end and its payload FIFO.
package dsi_ahb_pkg;

  typedef enum logic [1:0] {
    HTRANS_IDLE   = 2'b00,
    HTRANS_BUSY   = 2'b01,
    HTRANS_NONSEQ = 2'b10,
    HTRANS_SEQ    = 2'b11
  } htrans_e;

  typedef enum logic [1:0] {
    HRESP_OKAY  = 2'b00,
    HRESP_ERROR = 2'b01
  } hresp_e;

  localparam logic [2:0] HSIZE_WORD   = 3'b010;

  localparam logic [2:0] REG_CTRL     = 3'd0;
  localparam logic [2:0] REG_STATUS   = 3'd1;
  localparam logic [2:0] REG_HDR      = 3'd2;
  localparam logic [2:0] REG_PAYLOAD  = 3'd3;
  localparam logic [2:0] REG_IRQ_ST   = 3'd4;
  localparam logic [2:0] REG_IRQ_MASK = 3'd5;

  localparam int IRQ_PKT_DONE = 0;
  localparam int IRQ_FIFO_MT  = 1;

  localparam int CTRL_EN    = 0;
  localparam int CTRL_LP    = 1;
  localparam int CTRL_VC_LO = 2;
  localparam int CTRL_VC_HI = 3;

  typedef struct packed {
    logic       vld;
    logic [2:0] idx;
    logic       wr;
    logic       ok;
  } dphase_t;

  function automatic logic acc_legal(
    input logic [2:0] sz,
    input logic [1:0] lsb,
    input logic [2:0] idx,
    input logic       wr
  );
    return (sz == HSIZE_WORD) && (lsb == 2'b00) &&
           (idx <= REG_IRQ_MASK) &&
           !(wr && (idx == REG_STATUS));
  endfunction

endpackage

// File: rtl/dsi_ahb_if.sv
// dsi_ahb_if: AHB-lite signal bundle between bus master and
// the DSI register slave.
interface dsi_ahb_if;
  logic        hsel;
  logic [31:0] haddr;
  logic        hwrite;
  logic [2:0]  hsize;
  logic [2:0]  hburst;
  logic [1:0]  htrans;
  logic [31:0] hwdata;
  logic [3:0]  hprot;
  logic [31:0] hrdata;
  logic        hready;
  logic [1:0]  hresp;

  modport master (
    output hsel, haddr, hwrite, hsize, hburst,
    output htrans, hwdata, hprot,
    input  hrdata, hready, hresp
  );

  modport slave (
    input  hsel, haddr, hwrite, hsize, hburst,
    input  htrans, hwdata, hprot,
    output hrdata, hready, hresp
  );
endinterface

// File: rtl/dsi_ahb_slave_fifo.sv
// dsi_sync_fifo: single-clock payload FIFO, registered level,
// head word shown combinationally (zero while empty).
module dsi_sync_fifo #(
  parameter int DEPTH = 16,
  parameter int WIDTH = 32,
  localparam int AW = $clog2(DEPTH),
  localparam int LW = AW + 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push_i,
  input  logic [WIDTH-1:0] wdata_i,
  input  logic             pop_i,
  output logic [WIDTH-1:0] rdata_o,
  output logic             full_o,
  output logic             empty_o,
  output logic [LW-1:0]    level_o
);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wptr_q, rptr_q;
  logic [LW-1:0]    lvl_q, lvl_d;
  logic             do_push, do_pop;

  assign full_o  = (lvl_q == LW'(DEPTH));
  assign empty_o = (lvl_q == '0);
  assign level_o = lvl_q;
  assign do_push = push_i && !full_o;
  assign do_pop  = pop_i && !empty_o;
  assign lvl_d   = lvl_q + LW'(do_push) - LW'(do_pop);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wptr_q <= '0;
      rptr_q <= '0;
      lvl_q  <= '0;
    end else begin
      if (do_push) wptr_q <= wptr_q + 1'b1;
      if (do_pop)  rptr_q <= rptr_q + 1'b1;
      lvl_q <= lvl_d;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem_q[wptr_q] <= wdata_i;
  end

  assign rdata_o = empty_o ? '0 : mem_q[rptr_q];

endmodule

// File: rtl/dsi_ahb_slave.sv
// dsi_ahb_slave: AHB register front-end for the DSI controller.
// Define DSI_AHB_ERR_EN for two-cycle ERROR on illegal accesses.
module dsi_ahb_slave
  import dsi_ahb_pkg::*;
#(
  parameter int FIFO_DEPTH = 16
) (
  input  logic        clk,
  input  logic        hresetn,
  dsi_ahb_if.slave    bus,
  input  logic        pl_rd_en,
  output logic [31:0] pl_rdata,
  output logic        pl_empty,
  output logic        hdr_valid,
  output logic [23:0] hdr_data,
  output logic [3:0]  ctrl_out,
  input  logic        pkt_done,
  output logic        irq
);

  localparam int LVL_W = $clog2(FIFO_DEPTH) + 1;
`ifdef DSI_AHB_ERR_EN
  localparam bit ErrEn = 1'b1;
`else
  localparam bit ErrEn = 1'b0;
`endif
  localparam logic ST_DATA = 1'b0;
  localparam logic ST_ERR2 = 1'b1;

  dphase_t          dp_q, dp_d;
  logic             st_q, st_d;
  logic [3:0]       ctrl_q, ctrl_d;
  logic [23:0]      hdr_q, hdr_d;
  logic             hdrv_q, hdrv_d;
  logic [1:0]       mask_q, mask_d;
  logic [1:0]       irqst_q, irqst_d;
  logic [1:0]       w1c, set_ev;
  logic             irq_q, irq_d;
  logic             fifo_full, fifo_empty;
  logic [LVL_W-1:0] fifo_lvl;
  logic             addr_ph, bad, err1, stall;
  logic             hready, wr_ok, push, pop;
  logic [31:0]      rdata;
  logic             unused_bus;

  assign unused_bus = ^{bus.haddr[31:5], bus.hburst, bus.hprot};

  assign addr_ph = bus.hsel && hready &&
                   (bus.htrans == HTRANS_NONSEQ ||
                    bus.htrans == HTRANS_SEQ);
  assign bad   = dp_q.vld && !dp_q.ok;
  assign err1  = ErrEn && bad && (st_q == ST_DATA);
  assign stall = dp_q.vld && dp_q.ok && dp_q.wr &&
                 (dp_q.idx == REG_PAYLOAD) && fifo_full;
  assign hready = !(stall || err1);
  assign wr_ok  = dp_q.vld && dp_q.ok && dp_q.wr && hready;
  assign push   = wr_ok && (dp_q.idx == REG_PAYLOAD);
  assign pop    = pl_rd_en && !fifo_empty;
  assign st_d   = err1 ? ST_ERR2 : ST_DATA;

  always_comb begin
    dp_d = dp_q;
    if (hready) begin
      dp_d.vld = addr_ph;
      dp_d.idx = bus.haddr[4:2];
      dp_d.wr  = bus.hwrite;
      dp_d.ok  = acc_legal(bus.hsize, bus.haddr[1:0],
                           bus.haddr[4:2], bus.hwrite);
    end
  end

  always_comb begin
    ctrl_d = ctrl_q;
    hdr_d  = hdr_q;
    mask_d = mask_q;
    hdrv_d = 1'b0;
    w1c    = '0;
    unique case (1'b1)
      wr_ok && dp_q.idx == REG_CTRL:     ctrl_d = bus.hwdata[3:0];
      wr_ok && dp_q.idx == REG_HDR: begin
        hdr_d  = bus.hwdata[23:0];
        hdrv_d = 1'b1;
      end
      wr_ok && dp_q.idx == REG_IRQ_ST:   w1c    = bus.hwdata[1:0];
      wr_ok && dp_q.idx == REG_IRQ_MASK: mask_d = bus.hwdata[1:0];
      default: ;
    endcase
  end

  // a set event beats a same-cycle W1C on the same bit
  always_comb begin
    set_ev = '0;
    set_ev[IRQ_PKT_DONE] = pkt_done;
    set_ev[IRQ_FIFO_MT]  = pop && !push &&
                           (fifo_lvl == LVL_W'(1));
    irqst_d = (irqst_q & ~w1c) | set_ev;
    irq_d   = |(irqst_q & mask_q);
  end

  always_comb begin
    rdata = '0;
    if (dp_q.vld && dp_q.ok && !dp_q.wr) begin
      unique case (1'b1)
        dp_q.idx == REG_CTRL:     rdata[3:0]  = ctrl_q;
        dp_q.idx == REG_STATUS:
          rdata[LVL_W+1:0] = {fifo_empty, fifo_full, fifo_lvl};
        dp_q.idx == REG_HDR:      rdata[23:0] = hdr_q;
        dp_q.idx == REG_IRQ_ST:   rdata[1:0]  = irqst_q;
        dp_q.idx == REG_IRQ_MASK: rdata[1:0]  = mask_q;
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!hresetn) begin
      dp_q    <= '0;
      st_q    <= ST_DATA;
      ctrl_q  <= '0;
      hdr_q   <= '0;
      hdrv_q  <= 1'b0;
      mask_q  <= '0;
      irqst_q <= '0;
      irq_q   <= 1'b0;
    end else begin
      dp_q    <= dp_d;
      st_q    <= st_d;
      ctrl_q  <= ctrl_d;
      hdr_q   <= hdr_d;
      hdrv_q  <= hdrv_d;
      mask_q  <= mask_d;
      irqst_q <= irqst_d;
      irq_q   <= irq_d;
    end
  end

  dsi_sync_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (32)
  ) u_fifo (
    .clk     (clk),
    .rst_n   (hresetn),
    .push_i  (push),
    .wdata_i (bus.hwdata),
    .pop_i   (pl_rd_en),
    .rdata_o (pl_rdata),
    .full_o  (fifo_full),
    .empty_o (fifo_empty),
    .level_o (fifo_lvl)
  );

  assign bus.hready = hready;
  assign bus.hresp  = (ErrEn && bad) ? HRESP_ERROR : HRESP_OKAY;
  assign bus.hrdata = rdata;
  assign pl_empty   = fifo_empty;
  assign hdr_valid  = hdrv_q;
  assign hdr_data   = hdr_q;
  assign ctrl_out   = {ctrl_q[CTRL_VC_HI:CTRL_VC_LO],
                       ctrl_q[CTRL_LP], ctrl_q[CTRL_EN]};
  assign irq        = irq_q;

endmodule

// File: tb/tb_dsi_ahb_slave.sv
// tb_dsi_ahb_slave: directed + randomized checks of the DSI AHB
// slave against a register/queue model kept in the bench.
module tb_dsi_ahb_slave;

  localparam int DEPTH = 16;
  localparam int LVL   = $clog2(DEPTH) + 1;
`ifdef DSI_AHB_ERR_EN
  localparam bit ERR = 1'b1;
`else
  localparam bit ERR = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        hresetn = 1'b0;
  logic        pl_rd_en = 1'b0;
  logic        pkt_done = 1'b0;
  logic [31:0] pl_rdata;
  logic        pl_empty, hdr_valid, irq;
  logic [23:0] hdr_data;
  logic [3:0]  ctrl_out;

  dsi_ahb_if bus();

  dsi_ahb_slave #(.FIFO_DEPTH(DEPTH)) dut (
    .clk       (clk),
    .hresetn   (hresetn),
    .bus       (bus),
    .pl_rd_en  (pl_rd_en),
    .pl_rdata  (pl_rdata),
    .pl_empty  (pl_empty),
    .hdr_valid (hdr_valid),
    .hdr_data  (hdr_data),
    .ctrl_out  (ctrl_out),
    .pkt_done  (pkt_done),
    .irq       (irq)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  logic [3:0]  m_ctrl;
  logic [23:0] m_hdr;
  logic [1:0]  m_mask, m_st;
  logic [31:0] m_q[$];
  logic [31:0] words[17];

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] st_exp(input int n);
    logic [31:0] v;
    v = n;
    if (n == 0)     v = v | (32'd1 << (LVL + 1));
    if (n == DEPTH) v = v | (32'd1 << LVL);
    return v;
  endfunction

  function automatic logic [31:0] rd_exp(input int idx);
    case (idx)
      0: return {28'd0, m_ctrl};
      1: return st_exp(m_q.size());
      2: return {8'd0, m_hdr};
      4: return {30'd0, m_st};
      5: return {30'd0, m_mask};
      default: return 32'd0;
    endcase
  endfunction

  // called at #1 after a posedge; returns at #1 after the edge
  // that closes the data phase
  task automatic xfer(input logic [31:0] a, input logic w,
                      input logic [31:0] d, input logic [2:0] sz,
                      input logic pd,
                      output logic [31:0] rd, output logic [1:0] rsp,
                      output logic rdy1, output logic [1:0] rsp1,
                      output int waits);
    bus.hsel = 1'b1;
    bus.haddr = a;
    bus.hwrite = w;
    bus.hsize = sz;
    bus.hburst = 3'b000;
    bus.htrans = 2'b10;
    @(posedge clk); #1;
    bus.hsel = 1'b0;
    bus.htrans = 2'b00;
    bus.hwdata = d;
    pkt_done = pd;
    @(negedge clk);
    rdy1 = bus.hready;
    rsp1 = bus.hresp;
    waits = 0;
    while (!bus.hready && waits < 40) begin
      @(negedge clk);
      waits++;
    end
    chk("xfer_bound", 32'(waits < 40), 32'd1);
    rd = bus.hrdata;
    rsp = bus.hresp;
    @(posedge clk); #1;
    pkt_done = 1'b0;
  endtask

  task automatic wr(input logic [31:0] a, input logic [31:0] d);
    logic [31:0] rd;
    logic [1:0]  rsp, rsp1;
    logic        rdy1;
    int          wt;
    xfer(a, 1'b1, d, 3'b010, 1'b0, rd, rsp, rdy1, rsp1, wt);
    chk("wr_resp", {30'd0, rsp}, 32'd0);
  endtask

  task automatic rdchk(input string tag, input logic [31:0] a,
                       input logic [31:0] exp,
                       input logic [1:0] exp_rsp);
    logic [31:0] rd;
    logic [1:0]  rsp, rsp1;
    logic        rdy1;
    int          wt;
    xfer(a, 1'b0, 32'd0, 3'b010, 1'b0, rd, rsp, rdy1, rsp1, wt);
    chk(tag, rd, exp);
    chk({tag, "_resp"}, {30'd0, rsp}, {30'd0, exp_rsp});
  endtask

  task automatic pop1();
    pl_rd_en = 1'b1;
    @(posedge clk); #1;
    pl_rd_en = 1'b0;
    if (m_q.size() > 0) begin
      void'(m_q.pop_front());
      if (m_q.size() == 0) m_st[1] = 1'b1;
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired checks=%0d", checks);
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] rd, d;
    logic [1:0]  rsp, rsp1;
    logic        rdy1;
    int          wt, op, idx;

    bus.hsel = 0; bus.haddr = 0; bus.hwrite = 0;
    bus.hsize = 3'b010; bus.hburst = 0; bus.htrans = 0;
    bus.hwdata = 0; bus.hprot = 0;
    m_ctrl = 0; m_hdr = 0; m_mask = 0; m_st = 0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_hready", 32'(bus.hready), 32'd1);
    chk("rst_hresp", 32'(bus.hresp), 32'd0);
    chk("rst_hrdata", bus.hrdata, 32'd0);
    chk("rst_empty", 32'(pl_empty), 32'd1);
    chk("rst_pl_rdata", pl_rdata, 32'd0);
    chk("rst_ctrl", 32'(ctrl_out), 32'd0);
    chk("rst_irq", 32'(irq), 32'd0);
    chk("rst_hdrv", 32'(hdr_valid), 32'd0);
    chk("rst_hdr", 32'(hdr_data), 32'd0);
    hresetn = 1'b1;
    @(posedge clk); #1;

    rdchk("status0", 32'h04, st_exp(0), 2'b00);

    wr(32'h00, 32'hA); m_ctrl = 4'hA;
    chk("ctrl_out", 32'(ctrl_out), 32'hA);
    rdchk("ctrl_rb", 32'h00, 32'hA, 2'b00);

    chk("hdrv_pre", 32'(hdr_valid), 32'd0);
    wr(32'h08, 32'h0003_4029); m_hdr = 24'h034029;
    chk("hdrv_pulse", 32'(hdr_valid), 32'd1);
    chk("hdr_data", 32'(hdr_data), 32'h034029);
    @(posedge clk); #1;
    chk("hdrv_drop", 32'(hdr_valid), 32'd0);
    rdchk("hdr_rb", 32'h08, 32'h034029, 2'b00);

    for (int i = 0; i < 17; i++) words[i] = $urandom;
    bus.hsel = 1; bus.haddr = 32'h0C; bus.hwrite = 1;
    bus.hsize = 3'b010; bus.hburst = 3'b001; bus.htrans = 2'b10;
    for (int i = 0; i < 17; i++) begin
      @(posedge clk); #1;
      bus.hwdata = words[i];
      if (i == 16) begin
        bus.htrans = 2'b00; bus.hsel = 0;
      end else begin
        bus.htrans = 2'b11;
      end
      @(negedge clk);
      if (i < 16) chk("burst_zero_wait", 32'(bus.hready), 32'd1);
    end
    for (int i = 0; i < 16; i++) m_q.push_back(words[i]);
    chk("burst_stall", 32'(bus.hready), 32'd0);
    chk("full_head", pl_rdata, words[0]);
    @(posedge clk); #1;
    @(negedge clk);
    chk("burst_stall2", 32'(bus.hready), 32'd0);
    @(posedge clk); #1;
    pl_rd_en = 1'b1;
    @(negedge clk);
    chk("pop_cycle_stall", 32'(bus.hready), 32'd0);
    @(posedge clk); #1;
    pl_rd_en = 1'b0;
    void'(m_q.pop_front());
    @(negedge clk);
    chk("stall_release", 32'(bus.hready), 32'd1);
    chk("head_after_pop", pl_rdata, words[1]);
    @(posedge clk); #1;
    m_q.push_back(words[16]);
    rdchk("status_full", 32'h04, st_exp(m_q.size()), 2'b00);

    while (m_q.size() > 0) begin
      chk("drain_head", pl_rdata, m_q[0]);
      pop1();
    end
    chk("drain_empty", 32'(pl_empty), 32'd1);
    rdchk("irq_mt", 32'h10, {30'd0, m_st}, 2'b00);

    wr(32'h10, 32'h3); m_st = 0;
    wr(32'h14, 32'h1); m_mask = 2'b01;
    rdchk("irq_clr", 32'h10, 32'd0, 2'b00);
    pkt_done = 1'b1;
    @(posedge clk); #1;
    pkt_done = 1'b0;
    m_st[0] = 1'b1;
    @(posedge clk); #1;
    chk("irq_set", 32'(irq), 32'd1);
    xfer(32'h10, 1'b1, 32'h1, 3'b010, 1'b1, rd, rsp, rdy1, rsp1, wt);
    rdchk("set_wins", 32'h10, 32'h1, 2'b00);
    wr(32'h10, 32'h1); m_st = 0;
    @(posedge clk); #1;
    chk("irq_clear", 32'(irq), 32'd0);

    xfer(32'h00, 1'b1, 32'h5, 3'b000, 1'b0, rd, rsp, rdy1, rsp1, wt);
    chk("err_rdy1", 32'(rdy1), ERR ? 32'd0 : 32'd1);
    chk("err_rsp1", 32'(rsp1), ERR ? 32'd1 : 32'd0);
    chk("err_rsp2", 32'(rsp), ERR ? 32'd1 : 32'd0);
    chk("err_waits", 32'(wt), ERR ? 32'd1 : 32'd0);
    chk("err_ctrl", 32'(ctrl_out), {28'd0, m_ctrl});
    rdchk("err_ctrl_rb", 32'h00, {28'd0, m_ctrl}, 2'b00);

    for (int n = 0; n < 40; n++) begin
      op = $urandom_range(0, 6);
      d = $urandom;
      case (op)
        0: begin
          wr(32'h00, d); m_ctrl = d[3:0];
          chk("r_ctrl", 32'(ctrl_out), {28'd0, m_ctrl});
        end
        1: begin
          wr(32'h08, d); m_hdr = d[23:0];
          chk("r_hdrv", 32'(hdr_valid), 32'd1);
          chk("r_hdr", 32'(hdr_data), {8'd0, m_hdr});
        end
        2: begin wr(32'h14, d); m_mask = d[1:0]; end
        3: begin wr(32'h10, d); m_st = m_st & ~d[1:0]; end
        4: if (m_q.size() < DEPTH) begin
          wr(32'h0C, d); m_q.push_back(d);
        end
        5: if (m_q.size() > 0) begin
          chk("r_head", pl_rdata, m_q[0]);
          pop1();
        end
        default: begin
          idx = $urandom_range(0, 7);
          rdchk("r_read", 32'(idx * 4), rd_exp(idx),
                (ERR && idx > 5) ? 2'b01 : 2'b00);
        end
      endcase
      @(posedge clk); #1;
      chk("r_irq", 32'(irq), 32'(|(m_st & m_mask)));
      chk("r_empty", 32'(pl_empty), 32'(m_q.size() == 0));
    end

    bus.hsel = 1; bus.haddr = 32'h00; bus.hwrite = 1;
    bus.hsize = 3'b010; bus.htrans = 2'b10;
    @(posedge clk); #1;
    bus.hsel = 0; bus.htrans = 2'b00; bus.hwdata = 32'h3;
    hresetn = 1'b0;
    @(posedge clk); #1;
    hresetn = 1'b1;
    @(posedge clk); #1;
    chk("abort_ctrl", 32'(ctrl_out), 32'd0);
    chk("abort_empty", 32'(pl_empty), 32'd1);
    chk("abort_hready", 32'(bus.hready), 32'd1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
